i2c_master_regs: RTL and testbench



---
 rtl/i2c_regs_pkg.sv | 34 +++
 rtl/i2c_master_regs.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_master_regs.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_regs_pkg.sv
// Shared register map, bit positions and FSM encoding for the I2C master
// register front end, the EEPROM sequencer and the byte controller.
package i2c_regs_pkg;

    localparam logic [2:0] ADDR_PRERLO = 3'd0;
    localparam logic [2:0] ADDR_PRERHI = 3'd1;
    localparam logic [2:0] ADDR_CTR    = 3'd2;
    localparam logic [2:0] ADDR_TXR    = 3'd3;
    localparam logic [2:0] ADDR_RXR    = 3'd3;
    localparam logic [2:0] ADDR_CR     = 3'd4;
    localparam logic [2:0] ADDR_SR     = 3'd4;

    localparam int unsigned CTR_EN  = 7;
    localparam int unsigned CTR_IEN = 6;

    localparam int unsigned CR_STA  = 7;
    localparam int unsigned CR_STO  = 6;
    localparam int unsigned CR_RD   = 5;
    localparam int unsigned CR_WR   = 4;
    localparam int unsigned CR_ACK  = 3;
    localparam int unsigned CR_IACK = 0;

    localparam int unsigned SR_RXACK = 7;
    localparam int unsigned SR_BUSY  = 6;
    localparam int unsigned SR_AL    = 5;
    localparam int unsigned SR_TIP   = 1;
    localparam int unsigned SR_IF    = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/i2c_master_regs.sv
// Register front end of the I2C master: decodes write/read strobes into the
// register set and hands byte commands to the byte controller.
module i2c_master_regs
    import i2c_regs_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter logic [15:0] PRER_RST = 16'hFFFF
) (
    input  logic          I_CLK,
    input  logic          I_RESETN,
    input  logic          I_TX_EN,
    input  logic [2:0]    I_WADDR,
    input  logic [DW-1:0] I_WDATA,
    input  logic          I_RX_EN,
    input  logic [2:0]    I_RADDR,
    output logic [DW-1:0] O_RDATA,
    output logic          o_core_en,
    output logic [15:0]   o_prescale,
    output logic          o_cmd_valid,
    output logic          o_cmd_sta,
    output logic          o_cmd_sto,
    output logic          o_cmd_rd,
    output logic          o_cmd_wr,
    output logic          o_cmd_nack,
    output logic [7:0]    o_txd,
    input  logic          i_cmd_done,
    input  logic [7:0]    i_rxd,
    input  logic          i_rx_ack,
    input  logic          i_bus_busy,
    input  logic          i_arb_lost,
    output logic          o_irq,
    output state_t        o_dbg_state
);

    // Command handshake: o_cmd_valid rises the cycle after an accepted CR
    // write and the command bits stay frozen until i_cmd_done, i_arb_lost or
    // CTR.EN clearing takes the FSM back to IDLE.

    state_t        state_q, state_d;
    logic [15:0]   prer_q, prer_d;
    logic          ctr_en_q, ctr_en_d;
    logic          ctr_ien_q, ctr_ien_d;
    logic [7:0]    txr_q, txr_d;
    logic [7:0]    rxr_q, rxr_d;
    logic          sta_q, sta_d, sto_q, sto_d, rd_q, rd_d, wr_q, wr_d, nack_q, nack_d;
    logic          rx_ack_q, rx_ack_d;
    logic          busy_q, busy_d;
    logic          al_q, al_d;
    logic          if_q, if_d;
    logic          irq_q, irq_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [7:0]    wdata;
    logic [7:0]    sr_byte;
    logic [7:0]    rd_byte;
    logic          cr_wr;
    logic          cmd_req;

    assign wdata   = I_WDATA[7:0];
    assign sr_byte = {rx_ack_q, busy_q, al_q, 3'b000, (state_q == ST_BUSY), if_q};
    assign cr_wr   = I_TX_EN && (I_WADDR == ADDR_CR) && ctr_en_q;
    assign cmd_req = cr_wr && (|wdata[CR_STA:CR_WR]);

    always_comb begin
        rd_byte = 8'h00;
        case (I_RADDR)
            ADDR_PRERLO: rd_byte = prer_q[7:0];
            ADDR_PRERHI: rd_byte = prer_q[15:8];
            ADDR_CTR:    rd_byte = {ctr_en_q, ctr_ien_q, 6'b000000};
            ADDR_RXR:    rd_byte = rxr_q;
            ADDR_SR:     rd_byte = sr_byte;
            default:     rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        prer_d    = prer_q;
        ctr_en_d  = ctr_en_q;
        ctr_ien_d = ctr_ien_q;
        txr_d     = txr_q;
        rxr_d     = rxr_q;
        sta_d     = sta_q;
        sto_d     = sto_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        nack_d    = nack_q;
        rx_ack_d  = rx_ack_q;
        al_d      = al_q;
        if_d      = if_q;
        busy_d    = i_bus_busy;
        irq_d     = if_q & ctr_ien_q;
        rdata_d   = rdata_q;

        if (I_RX_EN) begin
            rdata_d = DW'(rd_byte);
        end

        if (I_TX_EN) begin
            case (I_WADDR)
                ADDR_PRERLO: if (!ctr_en_q) prer_d[7:0]  = wdata;
                ADDR_PRERHI: if (!ctr_en_q) prer_d[15:8] = wdata;
                ADDR_CTR: begin
                    ctr_en_d  = wdata[CTR_EN];
                    ctr_ien_d = wdata[CTR_IEN];
                end
                ADDR_TXR:    txr_d = wdata;
                default: ;
            endcase
        end

        // IACK is evaluated first so that a same-cycle completion re-sets IF.
        if (cr_wr && wdata[CR_IACK]) begin
            if_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_req) begin
                    state_d = ST_BUSY;
                    sta_d   = wdata[CR_STA];
                    sto_d   = wdata[CR_STO];
                    rd_d    = wdata[CR_RD];
                    wr_d    = wdata[CR_WR];
                    nack_d  = wdata[CR_ACK];
                    if (wdata[CR_STA]) al_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (i_arb_lost) begin
                    state_d = ST_IDLE;
                    al_d    = 1'b1;
                    if_d    = 1'b1;
                end else if (i_cmd_done) begin
                    state_d  = ST_IDLE;
                    if_d     = 1'b1;
                    rx_ack_d = i_rx_ack;
                    if (rd_q) rxr_d = i_rxd;
                end else if (!ctr_en_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            sta_d  = 1'b0;
            sto_d  = 1'b0;
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            nack_d = 1'b0;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q   <= ST_IDLE;
            prer_q    <= PRER_RST;
            ctr_en_q  <= 1'b0;
            ctr_ien_q <= 1'b0;
            txr_q     <= 8'h00;
            rxr_q     <= 8'h00;
            sta_q     <= 1'b0;
            sto_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            nack_q    <= 1'b0;
            rx_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            al_q      <= 1'b0;
            if_q      <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prer_q    <= prer_d;
            ctr_en_q  <= ctr_en_d;
            ctr_ien_q <= ctr_ien_d;
            txr_q     <= txr_d;
            rxr_q     <= rxr_d;
            sta_q     <= sta_d;
            sto_q     <= sto_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            nack_q    <= nack_d;
            rx_ack_q  <= rx_ack_d;
            busy_q    <= busy_d;
            al_q      <= al_d;
            if_q      <= if_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign O_RDATA     = rdata_q;
    assign o_core_en   = ctr_en_q;
    assign o_prescale  = prer_q;
    assign o_cmd_valid = (state_q == ST_BUSY);
    assign o_cmd_sta   = sta_q;
    assign o_cmd_sto   = sto_q;
    assign o_cmd_rd    = rd_q;
    assign o_cmd_wr    = wr_q;
    assign o_cmd_nack  = nack_q;
    assign o_txd       = txr_q;
    assign o_irq       = irq_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master_regs.sv
// Directed bench for i2c_master_regs: register reads go through an expected
// queue checked by a monitor; control outputs are checked directly.
module tb_i2c_master_regs;
    import i2c_regs_pkg::*;

    logic        I_CLK;
    logic        I_RESETN;
    logic        I_TX_EN;
    logic [2:0]  I_WADDR;
    logic [7:0]  I_WDATA;
    logic        I_RX_EN;
    logic [2:0]  I_RADDR;
    logic [7:0]  O_RDATA;
    logic        o_core_en;
    logic [15:0] o_prescale;
    logic        o_cmd_valid;
    logic        o_cmd_sta, o_cmd_sto, o_cmd_rd, o_cmd_wr, o_cmd_nack;
    logic [7:0]  o_txd;
    logic        i_cmd_done;
    logic [7:0]  i_rxd;
    logic        i_rx_ack;
    logic        i_bus_busy;
    logic        i_arb_lost;
    logic        o_irq;
    state_t      o_dbg_state;

    int          n_vec;
    int          n_err;
    logic [7:0]  exp_q[$];

    i2c_master_regs #(.DW(8), .PRER_RST(16'hFFFF)) dut (
        .I_CLK(I_CLK), .I_RESETN(I_RESETN),
        .I_TX_EN(I_TX_EN), .I_WADDR(I_WADDR), .I_WDATA(I_WDATA),
        .I_RX_EN(I_RX_EN), .I_RADDR(I_RADDR), .O_RDATA(O_RDATA),
        .o_core_en(o_core_en), .o_prescale(o_prescale),
        .o_cmd_valid(o_cmd_valid), .o_cmd_sta(o_cmd_sta), .o_cmd_sto(o_cmd_sto),
        .o_cmd_rd(o_cmd_rd), .o_cmd_wr(o_cmd_wr), .o_cmd_nack(o_cmd_nack),
        .o_txd(o_txd), .i_cmd_done(i_cmd_done), .i_rxd(i_rxd),
        .i_rx_ack(i_rx_ack), .i_bus_busy(i_bus_busy), .i_arb_lost(i_arb_lost),
        .o_irq(o_irq), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge I_CLK);
        I_TX_EN = 1'b1; I_WADDR = a; I_WDATA = d;
        @(negedge I_CLK);
        I_TX_EN = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, input logic [7:0] exp);
        @(negedge I_CLK);
        I_RX_EN = 1'b1; I_RADDR = a;
        exp_q.push_back(exp);
        @(negedge I_CLK);
        I_RX_EN = 1'b0;
    endtask

    task automatic reg_write_read(input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
        @(negedge I_CLK);
        I_TX_EN = 1'b1; I_WADDR = a; I_WDATA = d;
        I_RX_EN = 1'b1; I_RADDR = a;
        exp_q.push_back(exp);
        @(negedge I_CLK);
        I_TX_EN = 1'b0; I_RX_EN = 1'b0;
    endtask

    task automatic ctl_pulse(input logic done, input logic arb, input logic [7:0] rxd, input logic ack);
        @(negedge I_CLK);
        i_cmd_done = done; i_arb_lost = arb; i_rxd = rxd; i_rx_ack = ack;
        @(negedge I_CLK);
        i_cmd_done = 1'b0; i_arb_lost = 1'b0;
    endtask

    // scoreboard monitor: O_RDATA is compared the cycle after each read strobe
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge I_CLK);
            if (I_RX_EN && I_RESETN) begin
                @(negedge I_CLK);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rdata: got %h with no expected value queued", O_RDATA);
                end else begin
                    e = exp_q.pop_front();
                    if (O_RDATA !== e) begin
                        n_err++;
                        $display("FAIL rdata: got %h expected %h", O_RDATA, e);
                    end
                end
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0;
        I_RESETN = 1'b0; I_TX_EN = 1'b0; I_WADDR = '0; I_WDATA = '0;
        I_RX_EN = 1'b0; I_RADDR = '0; i_cmd_done = 1'b0; i_rxd = '0;
        i_rx_ack = 1'b0; i_bus_busy = 1'b0; i_arb_lost = 1'b0;
        repeat (3) @(negedge I_CLK);
        check("rst_cmd_valid", 16'(o_cmd_valid), 16'h0);
        check("rst_irq", 16'(o_irq), 16'h0);
        check("rst_prescale", o_prescale, 16'hFFFF);
        check("rst_rdata", 16'(O_RDATA), 16'h0);
        check("rst_state", 16'(o_dbg_state), 16'(ST_IDLE));
        I_RESETN = 1'b1;

        reg_read(3'd0, 8'hFF);
        reg_read(3'd1, 8'hFF);
        reg_read(3'd4, 8'h00);
        reg_read(3'd2, 8'h00);

        // prescale locked once enabled
        reg_write(3'd0, 8'h63);
        reg_write(3'd1, 8'h00);
        reg_write(3'd2, 8'h80);
        reg_write(3'd0, 8'h11);
        check("prescale_lock", o_prescale, 16'h0063);
        check("core_en", 16'(o_core_en), 16'h1);
        reg_read(3'd0, 8'h63);

        // START + WRITE
        reg_write(3'd3, 8'hA0);
        reg_write(3'd4, 8'h90);
        check("cmd_valid_sw", 16'(o_cmd_valid), 16'h1);
        check("cmd_bits_sw", 16'({o_cmd_sta, o_cmd_sto, o_cmd_rd, o_cmd_wr, o_cmd_nack}), 16'b10010);
        check("txd", 16'(o_txd), 16'h00A0);
        reg_read(3'd4, 8'h02);
        ctl_pulse(1'b1, 1'b0, 8'h00, 1'b0);
        check("cmd_valid_done", 16'(o_cmd_valid), 16'h0);
        reg_read(3'd4, 8'h01);
        check("irq_ien_off", 16'(o_irq), 16'h0);

        // READ with NACK; CR write while busy must not disturb command bits
        reg_write(3'd4, 8'h28);
        check("cmd_bits_rd", 16'({o_cmd_sta, o_cmd_sto, o_cmd_rd, o_cmd_wr, o_cmd_nack}), 16'b00101);
        reg_write(3'd4, 8'h40);
        check("cmd_bits_frozen", 16'({o_cmd_sta, o_cmd_sto, o_cmd_rd, o_cmd_wr, o_cmd_nack}), 16'b00101);
        check("cmd_valid_frozen", 16'(o_cmd_valid), 16'h1);
        ctl_pulse(1'b1, 1'b0, 8'h06, 1'b1);
        reg_read(3'd3, 8'h06);
        reg_read(3'd4, 8'h81);

        // interrupts, IACK, arbitration lost beating done
        reg_write(3'd2, 8'hC0);
        reg_read(3'd2, 8'hC0);
        check("irq_on", 16'(o_irq), 16'h1);
        reg_write(3'd4, 8'h01);
        reg_read(3'd4, 8'h80);
        check("irq_iack", 16'(o_irq), 16'h0);
        reg_write(3'd4, 8'hA0);
        check("cmd_valid_al", 16'(o_cmd_valid), 16'h1);
        ctl_pulse(1'b1, 1'b1, 8'h55, 1'b0);
        check("cmd_valid_al_drop", 16'(o_cmd_valid), 16'h0);
        reg_read(3'd3, 8'h06);
        reg_read(3'd4, 8'hA1);
        check("irq_al", 16'(o_irq), 16'h1);
        reg_write(3'd4, 8'h01);
        reg_read(3'd4, 8'hA0);
        check("irq_al_iack", 16'(o_irq), 16'h0);

        // BUSY mirrors the bus
        @(negedge I_CLK);
        i_bus_busy = 1'b1;
        repeat (2) @(negedge I_CLK);
        reg_read(3'd4, 8'hE0);
        i_bus_busy = 1'b0;
        repeat (2) @(negedge I_CLK);

        // disabling the core aborts a pending command
        reg_write(3'd4, 8'h10);
        check("cmd_valid_wr", 16'(o_cmd_valid), 16'h1);
        reg_write(3'd2, 8'h00);
        check("cmd_valid_en_off", 16'(o_cmd_valid), 16'h0);
        check("state_en_off", 16'(o_dbg_state), 16'(ST_IDLE));
        reg_read(3'd4, 8'hA0);

        // unmapped addresses
        reg_read(3'd5, 8'h00);
        reg_write(3'd5, 8'hFF);
        reg_read(3'd7, 8'h00);

        // same-cycle write and read returns the old value
        reg_write_read(3'd0, 8'h22, 8'h63);
        reg_read(3'd0, 8'h22);

        // asynchronous reset during BUSY
        reg_write(3'd2, 8'hC0);
        reg_write(3'd4, 8'h80);
        check("cmd_valid_pre_rst", 16'(o_cmd_valid), 16'h1);
        @(posedge I_CLK);
        #2 I_RESETN = 1'b0;
        #1;
        check("arst_cmd_valid", 16'(o_cmd_valid), 16'h0);
        check("arst_prescale", o_prescale, 16'hFFFF);
        check("arst_core_en", 16'(o_core_en), 16'h0);
        check("arst_irq", 16'(o_irq), 16'h0);
        check("arst_rdata", 16'(O_RDATA), 16'h0);
        check("arst_cmd_sta", 16'(o_cmd_sta), 16'h0);
        @(negedge I_CLK);
        I_RESETN = 1'b1;
        reg_read(3'd0, 8'hFF);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge I_CLK);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d reads never answered, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
